// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, sequencer steps, control-strobe bundle.
package cpu_defs_pkg;
  localparam int OPC_W  = 5;
  localparam int STEP_W = 4;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [STEP_W-1:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } step_t;

  typedef struct packed {
    logic Run;
    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out;
    logic PC_enable, MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, ZHighIn;
    logic HI_enable, LO_enable, R_in, OutPort_enable, CON_enable;
    logic IncPC, MDR_read, RAM_write, Gra, Grb, Grc;
  } ctrl_t;

  // Final execute step of each opcode; reserved/nop/halt and all single-step
  // opcodes end at T3.
  function automatic step_t last_step(input logic [OPC_W-1:0] op);
    if (op == OP_LD || op == OP_ST) return ST_T7;
    else if (op <= OP_ORI)          return ST_T5;
    else if (op <= OP_DIV)          return ST_T6;
    else if (op <= OP_NOT)          return ST_T4;
    else if (op == OP_BR)           return ST_T6;
    else if (op == OP_JAL)          return ST_T4;
    else                            return ST_T3;
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: instruction/flag inputs, strobe outputs.
interface control_unit_if;
  import cpu_defs_pkg::*;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  ctrl_t       ctl;

  modport master (input IR, CON_FF, Stop, output ctl);
  modport slave  (output IR, CON_FF, Stop, input ctl);
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational strobe decode from (step, opcode, CON_FF).
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  step_t            step,
  input  logic [OPC_W-1:0] opc,
  input  logic             con_ff,
  output ctrl_t            ctl
);
  logic is_mem, is_alu_r, is_alu_i, is_md, is_un;

  assign is_mem   = (opc <= OP_ST);
  assign is_alu_r = (opc >= OP_ADD)  && (opc <= OP_ROL);
  assign is_alu_i = (opc >= OP_ADDI) && (opc <= OP_ORI);
  assign is_md    = (opc == OP_MUL)  || (opc == OP_DIV);
  assign is_un    = (opc == OP_NEG)  || (opc == OP_NOT);

  // Steps beyond an opcode's last step are never reached, so rows need no guard.
  always_comb begin
    ctl     = '0;
    ctl.Run = (step != ST_RESET) && (step != ST_HALT);
    unique case (step)
      ST_T0: begin ctl.PCout = 1'b1; ctl.MAR_enable = 1'b1; ctl.IncPC = 1'b1; ctl.ZLowIn = 1'b1; end
      ST_T1: begin ctl.ZLowout = 1'b1; ctl.PC_enable = 1'b1; ctl.MDR_read = 1'b1; ctl.MDR_enable = 1'b1; end
      ST_T2: begin ctl.MDRout = 1'b1; ctl.IR_enable = 1'b1; end
      ST_T3: begin
        if (is_mem) begin ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Y_enable = 1'b1; end
        if (is_alu_r || is_alu_i) begin ctl.Grb = 1'b1; ctl.R_out = 1'b1; ctl.Y_enable = 1'b1; end
        if (is_md) begin ctl.Gra = 1'b1; ctl.R_out = 1'b1; ctl.Y_enable = 1'b1; end
        if (is_un) begin ctl.Grb = 1'b1; ctl.R_out = 1'b1; ctl.ZLowIn = 1'b1; end
        if (opc == OP_BR)   begin ctl.Gra = 1'b1; ctl.R_out = 1'b1; ctl.CON_enable = 1'b1; end
        if (opc == OP_JR)   begin ctl.Gra = 1'b1; ctl.R_out = 1'b1; ctl.PC_enable = 1'b1; end
        if (opc == OP_JAL)  begin ctl.PCout = 1'b1; ctl.Grb = 1'b1; ctl.R_in = 1'b1; end
        if (opc == OP_IN)   begin ctl.InPortout = 1'b1; ctl.Gra = 1'b1; ctl.R_in = 1'b1; end
        if (opc == OP_OUT)  begin ctl.Gra = 1'b1; ctl.R_out = 1'b1; ctl.OutPort_enable = 1'b1; end
        if (opc == OP_MFHI) begin ctl.HIout = 1'b1; ctl.Gra = 1'b1; ctl.R_in = 1'b1; end
        if (opc == OP_MFLO) begin ctl.LOout = 1'b1; ctl.Gra = 1'b1; ctl.R_in = 1'b1; end
      end
      ST_T4: begin
        if (is_mem || is_alu_i) begin ctl.Cout = 1'b1; ctl.ZLowIn = 1'b1; end
        if (is_alu_r) begin ctl.Grc = 1'b1; ctl.R_out = 1'b1; ctl.ZLowIn = 1'b1; end
        if (is_md) begin ctl.Grb = 1'b1; ctl.R_out = 1'b1; ctl.ZLowIn = 1'b1; ctl.ZHighIn = 1'b1; end
        if (is_un) begin ctl.ZLowout = 1'b1; ctl.Gra = 1'b1; ctl.R_in = 1'b1; end
        if (opc == OP_BR)  begin ctl.PCout = 1'b1; ctl.Y_enable = 1'b1; end
        if (opc == OP_JAL) begin ctl.Gra = 1'b1; ctl.R_out = 1'b1; ctl.PC_enable = 1'b1; end
      end
      ST_T5: begin
        if (opc == OP_LDI || is_alu_r || is_alu_i) begin ctl.ZLowout = 1'b1; ctl.Gra = 1'b1; ctl.R_in = 1'b1; end
        if (opc == OP_LD || opc == OP_ST) begin ctl.ZLowout = 1'b1; ctl.MAR_enable = 1'b1; end
        if (is_md) begin ctl.ZLowout = 1'b1; ctl.LO_enable = 1'b1; end
        if (opc == OP_BR) begin ctl.Cout = 1'b1; ctl.ZLowIn = 1'b1; end
      end
      ST_T6: begin
        if (opc == OP_LD) begin ctl.MDR_read = 1'b1; ctl.MDR_enable = 1'b1; end
        if (opc == OP_ST) begin ctl.Gra = 1'b1; ctl.R_out = 1'b1; ctl.MDR_enable = 1'b1; end
        if (is_md) begin ctl.ZHighout = 1'b1; ctl.HI_enable = 1'b1; end
        if (opc == OP_BR) begin ctl.ZLowout = 1'b1; ctl.PC_enable = con_ff; end
      end
      ST_T7: begin
        if (opc == OP_LD) begin ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.R_in = 1'b1; end
        if (opc == OP_ST) ctl.RAM_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: step register, next-step logic, Stop/halt handling.
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic Clock,
  input  logic Clear,
  control_unit_if.master bus
);
  step_t            step, step_nx;
  logic [OPC_W-1:0] opc;
  ctrl_t            ctl;

  assign opc = bus.IR[31 -: OPC_W];

  // Step register; Clear aborts any instruction immediately.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) step <= ST_RESET;
    else       step <= step_nx;
  end

  // Advance through the steps; at an instruction boundary go to HALT on
  // halt opcode or a pending Stop, otherwise back to fetch.
  always_comb begin
    step_nx = step;
    unique case (step)
      ST_RESET: step_nx = ST_T0;
      ST_HALT:  step_nx = ST_HALT;
      default: begin
        if (step == last_step(opc))
          step_nx = (opc == OP_HALT || bus.Stop) ? ST_HALT : ST_T0;
        else
          step_nx = step_t'(step + 4'd1);
      end
    endcase
  end

  ctrl_decode u_dec (
    .step   (step),
    .opc    (opc),
    .con_ff (bus.CON_FF),
    .ctl    (ctl)
  );

  assign bus.ctl = ctl;
endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench: per-instruction expected strobe sequences
// are built from the instruction table and compared cycle by cycle.
module tb_control_unit;
  import cpu_defs_pkg::*;

  logic Clock = 1'b0;
  logic Clear = 1'b1;
  control_unit_if bus();

  control_unit dut (.Clock(Clock), .Clear(Clear), .bus(bus));

  always #5 Clock = ~Clock;

  int    n_chk  = 0;
  int    n_pass = 0;
  ctrl_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic ctrl_t run1();
    ctrl_t r = '0;
    r.Run = 1'b1;
    return r;
  endfunction

  function automatic int drives(input ctrl_t c);
    return int'(c.PCout) + int'(c.ZLowout) + int'(c.ZHighout) + int'(c.MDRout) +
           int'(c.HIout) + int'(c.LOout) + int'(c.InPortout) + int'(c.Cout) +
           int'(c.BAout) + int'(c.R_out);
  endfunction

  // Expected per-cycle strobes of one whole instruction, fetch included.
  task automatic build(input logic [4:0] op, input bit con);
    ctrl_t s;
    int    o = int'(op);
    exp_q.delete();
    s = run1(); s.PCout = 1; s.MAR_enable = 1; s.IncPC = 1; s.ZLowIn = 1; exp_q.push_back(s);
    s = run1(); s.ZLowout = 1; s.PC_enable = 1; s.MDR_read = 1; s.MDR_enable = 1; exp_q.push_back(s);
    s = run1(); s.MDRout = 1; s.IR_enable = 1; exp_q.push_back(s);
    if (o <= 2) begin
      s = run1(); s.Grb = 1; s.BAout = 1; s.Y_enable = 1; exp_q.push_back(s);
      s = run1(); s.Cout = 1; s.ZLowIn = 1; exp_q.push_back(s);
      if (o == 1) begin
        s = run1(); s.ZLowout = 1; s.Gra = 1; s.R_in = 1; exp_q.push_back(s);
      end else begin
        s = run1(); s.ZLowout = 1; s.MAR_enable = 1; exp_q.push_back(s);
        if (o == 0) begin
          s = run1(); s.MDR_read = 1; s.MDR_enable = 1; exp_q.push_back(s);
          s = run1(); s.MDRout = 1; s.Gra = 1; s.R_in = 1; exp_q.push_back(s);
        end else begin
          s = run1(); s.Gra = 1; s.R_out = 1; s.MDR_enable = 1; exp_q.push_back(s);
          s = run1(); s.RAM_write = 1; exp_q.push_back(s);
        end
      end
    end else if (o <= 13) begin
      s = run1(); s.Grb = 1; s.R_out = 1; s.Y_enable = 1; exp_q.push_back(s);
      s = run1();
      if (o <= 10) begin s.Grc = 1; s.R_out = 1; end else s.Cout = 1;
      s.ZLowIn = 1; exp_q.push_back(s);
      s = run1(); s.ZLowout = 1; s.Gra = 1; s.R_in = 1; exp_q.push_back(s);
    end else if (o <= 15) begin
      s = run1(); s.Gra = 1; s.R_out = 1; s.Y_enable = 1; exp_q.push_back(s);
      s = run1(); s.Grb = 1; s.R_out = 1; s.ZLowIn = 1; s.ZHighIn = 1; exp_q.push_back(s);
      s = run1(); s.ZLowout = 1; s.LO_enable = 1; exp_q.push_back(s);
      s = run1(); s.ZHighout = 1; s.HI_enable = 1; exp_q.push_back(s);
    end else if (o <= 17) begin
      s = run1(); s.Grb = 1; s.R_out = 1; s.ZLowIn = 1; exp_q.push_back(s);
      s = run1(); s.ZLowout = 1; s.Gra = 1; s.R_in = 1; exp_q.push_back(s);
    end else if (o == 18) begin
      s = run1(); s.Gra = 1; s.R_out = 1; s.CON_enable = 1; exp_q.push_back(s);
      s = run1(); s.PCout = 1; s.Y_enable = 1; exp_q.push_back(s);
      s = run1(); s.Cout = 1; s.ZLowIn = 1; exp_q.push_back(s);
      s = run1(); s.ZLowout = 1; s.PC_enable = con; exp_q.push_back(s);
    end else if (o == 19) begin
      s = run1(); s.Gra = 1; s.R_out = 1; s.PC_enable = 1; exp_q.push_back(s);
    end else if (o == 20) begin
      s = run1(); s.PCout = 1; s.Grb = 1; s.R_in = 1; exp_q.push_back(s);
      s = run1(); s.Gra = 1; s.R_out = 1; s.PC_enable = 1; exp_q.push_back(s);
    end else begin
      s = run1();
      case (o)
        21: begin s.InPortout = 1; s.Gra = 1; s.R_in = 1; end
        22: begin s.Gra = 1; s.R_out = 1; s.OutPort_enable = 1; end
        23: begin s.HIout = 1; s.Gra = 1; s.R_in = 1; end
        24: begin s.LOout = 1; s.Gra = 1; s.R_in = 1; end
        default: ;
      endcase
      exp_q.push_back(s);
    end
  endtask

  // Runs one instruction starting at its T0. stop_at/abort_at are cycle
  // indices within the instruction (-1 = none); hold = HALT cycles checked.
  task automatic run_instr(input logic [4:0] op, input bit con, input int stop_at,
                           input int abort_at, input int hold);
    bit halt_exp;
    int sa;
    build(op, con);
    sa = (stop_at >= exp_q.size()) ? exp_q.size() - 1 : stop_at;
    halt_exp = (op == OP_HALT) || (sa >= 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) begin
        bus.IR = {op, 27'($urandom)};
        bus.CON_FF = con;
        bus.Stop = 1'b0;
      end
      if (i == sa) bus.Stop = 1'b1;
      #1;
      chk($sformatf("op%0d_c%0d_s%0d", op, con, i), 64'(bus.ctl), 64'(exp_q[i]));
      chk($sformatf("excl_op%0d_s%0d", op, i), 64'(drives(bus.ctl) <= 1), 64'd1);
      if (i == abort_at) begin
        Clear = 1'b1;
        #1;
        chk($sformatf("abort_op%0d_s%0d", op, i), 64'(bus.ctl), 64'd0);
        @(negedge Clock);
        Clear = 1'b0;
        bus.Stop = 1'b0;
        return;
      end
    end
    if (halt_exp) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge Clock);
        #1;
        chk($sformatf("halt_op%0d_k%0d", op, k), 64'(bus.ctl), 64'd0);
      end
      Clear = 1'b1;
      bus.Stop = 1'b0;
      @(negedge Clock);
      Clear = 1'b0;
    end
  endtask

  initial begin
    bus.IR = '0;
    bus.CON_FF = 1'b0;
    bus.Stop = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    chk("reset", 64'(bus.ctl), 64'd0);
    Clear = 1'b0;

    // Directed: ld, add aborted in T4 then add, branch both ways, mflo with Stop, halt.
    run_instr(OP_LD,   1'b0, -1, -1, 0);
    run_instr(OP_ADD,  1'b0, -1,  4, 0);
    run_instr(OP_ADD,  1'b1, -1, -1, 0);
    run_instr(OP_BR,   1'b1, -1, -1, 0);
    run_instr(OP_BR,   1'b0, -1, -1, 0);
    run_instr(OP_MFLO, 1'b0,  1, -1, 5);
    run_instr(OP_HALT, 1'b0, -1, -1, 20);

    // Every opcode, both CON_FF values.
    for (int o = 0; o < 32; o++)
      for (int c = 0; c < 2; c++)
        run_instr(5'(o), c[0], -1, -1, 2);

    // Random program with occasional Stop or Clear.
    for (int n = 0; n < 150; n++) begin
      int r  = int'($urandom_range(0, 19));
      int sa = (r == 0) ? int'($urandom_range(0, 7)) : -1;
      int ab = (r == 1) ? int'($urandom_range(0, 7)) : -1;
      run_instr(5'($urandom_range(0, 31)), 1'($urandom), sa, ab, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer that sits directly upstream of `datapath` and drives every control strobe the datapath consumes.
- Per instruction it runs the fetch steps T0–T2, decodes IR[31:27] and runs that opcode's execute steps (T3–T7). It then returns to T0.
- It replaces hand-sequenced testbench stimulus, so the datapath can run programs from memory unattended.

Parameters:
- OPC_W, 5, opcode field width (IR[31:27]).
- STEP_W, 4, state register width.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Clear  input  1  asynchronous, active-high reset.
- IR  input  32  instruction register contents from the datapath; only [31:27] is decoded.
- CON_FF  input  1  branch condition flag from the datapath CON logic.
- Stop  input  1  request to halt at the next instruction boundary.
- Run  output  1  high while sequencing; low in RESET and HALT.
- PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out  output  1 each  bus-drive selects.
- PC_enable, MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable, LO_enable, R_in, OutPort_enable, CON_enable  output  1 each  register load enables.
- IncPC, MDR_read, RAM_write, Gra, Grb, Grc  output  1 each  ALU PC-increment, MDR source select (memory), memory write, register-field selects.

Behaviour:
- **States:** RESET, T0..T7, HALT.
- **Outputs:** combinational, decoded from the state register and IR[31:27] only (pure Moore). No input other than CON_FF (branch, T6 only) affects the outputs.
- **Clear:** while high, state is forced to RESET asynchronously. In RESET every output is 0, including Run.
  - Clear mid-instruction aborts the instruction; no partial strobe survives the Clear edge.
- **Leaving reset:** RESET advances to T0 on the first rising edge after Clear falls.
- **Fetch (all opcodes):**
  - T0: PCout, MAR_enable, IncPC, ZLowIn.
  - T1: ZLowout, PC_enable, MDR_read, MDR_enable.
  - T2: MDRout, IR_enable.
- **Execute:** the opcode is decoded from IR during T3 onward. The final step of each row below is the last step; the following state is T0.
  - ld 00000: T3 Grb,BAout,Y_enable; T4 Cout,ZLowIn; T5 ZLowout,MAR_enable; T6 MDR_read,MDR_enable; T7 MDRout,Gra,R_in.
  - ldi 00001: T3 as ld; T4 as ld; T5 ZLowout,Gra,R_in.
  - st 00010: T3–T5 as ld; T6 Gra,R_out,MDR_enable (MDR_read=0); T7 RAM_write.
  - R-type ALU 00011–01010: T3 Grb,R_out,Y_enable; T4 Grc,R_out,ZLowIn; T5 ZLowout,Gra,R_in.
  - Immediate ALU 01011–01101: T3 Grb,R_out,Y_enable; T4 Cout,ZLowIn; T5 ZLowout,Gra,R_in.
  - mul/div 01110–01111: T3 Gra,R_out,Y_enable; T4 Grb,R_out,ZLowIn,ZHighIn; T5 ZLowout,LO_enable; T6 ZHighout,HI_enable.
  - neg/not 10000–10001: T3 Grb,R_out,ZLowIn; T4 ZLowout,Gra,R_in.
  - branch 10010: T3 Gra,R_out,CON_enable; T4 PCout,Y_enable; T5 Cout,ZLowIn; T6 ZLowout, plus PC_enable only if CON_FF=1.
  - jr 10011: T3 Gra,R_out,PC_enable.
  - jal 10100: T3 PCout,Grb,R_in (link register); T4 Gra,R_out,PC_enable.
  - in 10101: T3 InPortout,Gra,R_in.
  - out 10110: T3 Gra,R_out,OutPort_enable.
  - mfhi 10111: T3 HIout,Gra,R_in.
  - mflo 11000: T3 LOout,Gra,R_in.
  - nop 11001 and reserved 11011–11111: T3 with no strobes, then T0.
- **halt 11010:** T3 then HALT. HALT holds all outputs 0 and Run=0 until Clear.
- **Stop:** sampled on every last-step edge. If Stop=1, the next state is HALT instead of T0. Stop during fetch has no effect until that instruction's last step.
- **No overlap:** no two bus-drive selects are ever high in the same state.

Decomposition:
- Package `cpu_defs_pkg`:
  - opcode localparams, 5-bit, named per ISA (OP_LD=5'b00000 … OP_HALT=5'b11010);
  - step encodings RESET, T0..T7, HALT.
- The datapath and the testbenches share this package.
- One sub-module, `ctrl_decode`: purely combinational map from (step, opcode, CON_FF) to the output vector.
- `control_unit` keeps only the state register, next-state logic and Stop handling.

Test Plan:
- **Reset:** pulse Clear mid-T4 of an add → all outputs 0 in the same cycle. T0 strobes appear on the first rising edge after Clear falls, Run=1.
- **ld:** IR=32'h00900002 → 8 cycles T0–T7. T7 has MDRout=Gra=R_in=1; T6 has MDR_read=MDR_enable=1, RAM_write=0. Back to T0 on the next edge.
- **add:** IR opcode 00011 → T3 Grb&R_out&Y_enable, T4 Grc&R_out&ZLowIn, T5 ZLowout&Gra&R_in; 6-cycle instruction.
- **branch:** IR opcode 10010:
  - CON_FF=1 → PC_enable=1 in T6;
  - CON_FF=0 → PC_enable=0 in T6;
  - both cases reach T0 after T6.
- **halt and Stop:**
  - IR opcode 11010 → HALT after T3, Run=0 held for 20 cycles until Clear.
  - Separately, Stop=1 asserted during T1 of a mflo → instruction completes T3, then HALT.
- **Bus exclusivity:** sweep all 32 opcodes × all steps → at most one drive select high per state. Reserved opcodes behave as nop (T0–T3, 4 cycles).
